// File: rtl/ws2812_pkg.sv
// Shared constants, state encoding and timing helpers for the WS2812 strip driver.
package ws2812_pkg;

  localparam int T0H_NS_DEF  = 350;
  localparam int T0L_NS_DEF  = 800;
  localparam int T1H_NS_DEF  = 700;
  localparam int T1L_NS_DEF  = 600;
  localparam int TRES_NS_DEF = 80000;

  localparam logic [3:0] ST_IDLE_OH  = 4'b0001;
  localparam logic [3:0] ST_HIGH_OH  = 4'b0010;
  localparam logic [3:0] ST_LOW_OH   = 4'b0100;
  localparam logic [3:0] ST_LATCH_OH = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE_OH,
    S_HIGH  = ST_HIGH_OH,
    S_LOW   = ST_LOW_OH,
    S_LATCH = ST_LATCH_OH
  } state_t;

  // ceil(ns * f_clk / 1e9) in integer arithmetic
  function automatic int ns_to_cycles(input longint ns, input longint f_clk);
    return int'((ns * f_clk + 64'sd999_999_999) / 64'sd1_000_000_000);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_pix_buf.sv
// One-entry pixel holding register: valid/ready on the input, load strobe empties it.
module ws2812_pix_buf #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         ld_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // accept needs empty and load needs full, so the two never coincide
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (ld_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready_o = !full_q;
  assign full_o     = full_q;
  assign data_o     = data_q;

endmodule

// File: rtl/ws2812_strip.sv
// WS2812/SK6812 frame serialiser: streams N_LEDS pixels gap-free, then holds the latch low time.
module ws2812_strip
  import ws2812_pkg::*;
#(
  parameter real F_CLK   = 48e6,
  parameter int  BITS    = 24,
  parameter int  N_LEDS  = 8,
  parameter int  T0H_NS  = T0H_NS_DEF,
  parameter int  T0L_NS  = T0L_NS_DEF,
  parameter int  T1H_NS  = T1H_NS_DEF,
  parameter int  T1L_NS  = T1L_NS_DEF,
  parameter int  TRES_NS = TRES_NS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] pix_data,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic            dout,
  output logic            bsy,
  output logic            frame_done,
  output logic            underrun
);

  localparam longint F_HZ  = longint'(F_CLK);
  localparam int     N_T0H = ns_to_cycles(longint'(T0H_NS), F_HZ);
  localparam int     N_T0L = ns_to_cycles(longint'(T0L_NS), F_HZ);
  localparam int     N_T1H = ns_to_cycles(longint'(T1H_NS), F_HZ);
  localparam int     N_T1L = ns_to_cycles(longint'(T1L_NS), F_HZ);
  localparam int     N_RES = ns_to_cycles(longint'(TRES_NS), F_HZ);
  localparam int     N_MAX = max2(max2(max2(N_T0H, N_T0L), max2(N_T1H, N_T1L)), N_RES);
  localparam int     CW    = $clog2(N_MAX + 1);
  localparam int     PCW   = $clog2(N_LEDS + 1);
  localparam int     BW    = $clog2(BITS);

  if (BITS != 24 && BITS != 32) begin : g_bad_bits
    $error("ws2812_strip: BITS must be 24 or 32");
  end

  // counters are loaded with duration-1 so a phase lasts exactly N cycles
  function automatic logic [CW-1:0] hi_cnt(input logic b);
    return b ? CW'(N_T1H - 1) : CW'(N_T0H - 1);
  endfunction

  function automatic logic [CW-1:0] lo_cnt(input logic b);
    return b ? CW'(N_T1L - 1) : CW'(N_T0L - 1);
  endfunction

  logic            buf_full, ld;
  logic [BITS-1:0] buf_data;

  ws2812_pix_buf #(.W(BITS)) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .in_data_i (pix_data),
    .in_valid_i(pix_valid),
    .in_ready_o(pix_ready),
    .ld_i      (ld),
    .full_o    (buf_full),
    .data_o    (buf_data)
  );

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] sh_q, sh_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [PCW-1:0]  pix_q, pix_d;
  logic            cmpl_q, cmpl_d;
  logic            dout_q;
  logic            done_q, done_d;
  logic            urun_q, urun_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    cmpl_d  = cmpl_q;
    ld      = 1'b0;
    done_d  = 1'b0;
    urun_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (buf_full) begin
          ld      = 1'b1;
          sh_d    = buf_data;
          bit_d   = '0;
          pix_d   = '0;
          cnt_d   = hi_cnt(buf_data[BITS-1]);
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          cnt_d   = lo_cnt(sh_q[BITS-1]);
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bit_q != BW'(BITS - 1)) begin
          sh_d    = sh_q << 1;
          bit_d   = bit_q + 1'b1;
          cnt_d   = hi_cnt(sh_q[BITS-2]);
          state_d = S_HIGH;
        end else if (pix_q == PCW'(N_LEDS - 1)) begin
          cmpl_d  = 1'b1;
          cnt_d   = CW'(N_RES - 1);
          state_d = S_LATCH;
        end else if (buf_full) begin
          // next pixel goes straight into HIGH: no inter-pixel gap
          ld      = 1'b1;
          sh_d    = buf_data;
          bit_d   = '0;
          pix_d   = pix_q + 1'b1;
          cnt_d   = hi_cnt(buf_data[BITS-1]);
          state_d = S_HIGH;
        end else begin
          urun_d  = 1'b1;
          cmpl_d  = 1'b0;
          cnt_d   = CW'(N_RES - 1);
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          done_d  = cmpl_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      cmpl_q  <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      cmpl_q  <= cmpl_d;
      dout_q  <= (state_d == S_HIGH);
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign dout       = dout_q;
  assign bsy        = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_ws2812_strip.sv
// Bench for ws2812_strip: three instances (24b x1, 24b x3, 32b x1) checked against a pulse-level model.
module tb_ws2812_strip;

  localparam int N0H = 17, N0L = 39, N1H = 34, N1L = 29, NRES = 3840;
  localparam int ND  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [ND-1:0] pix_valid;
  logic [23:0]   pd0, pd1;
  logic [31:0]   pd2;
  wire  [ND-1:0] pix_ready, dout, bsy, frame_done, underrun;

  ws2812_strip #(.BITS(24), .N_LEDS(1)) u_a1 (
    .clk(clk), .rst(rst), .pix_data(pd0), .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
    .dout(dout[0]), .bsy(bsy[0]), .frame_done(frame_done[0]), .underrun(underrun[0]));
  ws2812_strip #(.BITS(24), .N_LEDS(3)) u_a3 (
    .clk(clk), .rst(rst), .pix_data(pd1), .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
    .dout(dout[1]), .bsy(bsy[1]), .frame_done(frame_done[1]), .underrun(underrun[1]));
  ws2812_strip #(.BITS(32), .N_LEDS(1)) u_b (
    .clk(clk), .rst(rst), .pix_data(pd2), .pix_valid(pix_valid[2]), .pix_ready(pix_ready[2]),
    .dout(dout[2]), .bsy(bsy[2]), .frame_done(frame_done[2]), .underrun(underrun[2]));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bits_of(input int i);
    return (i == 2) ? 32 : 24;
  endfunction

  function automatic int nleds_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int lowlen(input logic b);
    return b ? N1L : N0L;
  endfunction

  function automatic logic [31:0] mask(input logic [31:0] d, input int i);
    return (bits_of(i) == 24) ? (d & 32'h00FF_FFFF) : d;
  endfunction

  // ---- pulse-level monitor: decodes dout into bits/pixels and checks phase lengths
  typedef struct { int dut; logic [31:0] pix; } rx_t;
  rx_t rxq[$];

  int          run[ND], nb[ND], bsy_cnt[ND], last_len[ND];
  int          done_cnt[ND] = '{default: 0};
  int          urun_cnt[ND] = '{default: 0};
  logic        pdo[ND], pbs[ND], last_bit[ND], open_f[ND];
  logic [31:0] acc[ND];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) begin
        if (!rst) begin
          run[i] = 0; nb[i] = 0; bsy_cnt[i] = 0; acc[i] = '0;
          pdo[i] = 1'b0; pbs[i] = 1'b0; open_f[i] = 1'b0; last_bit[i] = 1'b0;
        end else begin
          if (pbs[i] && !bsy[i]) begin
            check("latch_low_len", 64'(run[i]), 64'(lowlen(last_bit[i]) + NRES));
            check("frame_whole_pixels", 64'(nb[i]), 64'd0);
            last_len[i] = bsy_cnt[i];
            bsy_cnt[i]  = 0;
            open_f[i]   = 1'b0;
          end
          if (bsy[i]) bsy_cnt[i]++;
          if (frame_done[i]) begin
            done_cnt[i]++;
            check("done_on_bsy_fall", {62'd0, pbs[i], bsy[i]}, 64'd2);
          end
          if (underrun[i]) begin
            urun_cnt[i]++;
            check("underrun_while_bsy", 64'(bsy[i]), 64'd1);
          end
          if (dout[i] !== pdo[i]) begin
            if (pdo[i]) begin
              last_bit[i] = (run[i] > 25);
              check("high_len", 64'(run[i]), 64'(last_bit[i] ? N1H : N0H));
              acc[i] = {acc[i][30:0], last_bit[i]};
              nb[i]++;
              if (nb[i] == bits_of(i)) begin
                rxq.push_back('{i, acc[i]});
                nb[i] = 0; acc[i] = '0;
              end
            end else if (open_f[i]) begin
              check("low_len", 64'(run[i]), 64'(lowlen(last_bit[i])));
            end else begin
              open_f[i] = 1'b1;
            end
            run[i] = 1;
          end else begin
            run[i]++;
          end
          pdo[i] = dout[i];
          pbs[i] = bsy[i];
        end
      end
    end
  end

  // ---- drivers (called in the low half of the clock)
  task automatic push(input int i, input logic [31:0] d);
    int t = 0;
    while (!pix_ready[i] && t < 20000) begin @(negedge clk); t++; end
    check("push_ready_wait", 64'(pix_ready[i]), 64'd1);
    case (i)
      0:       pd0 = d[23:0];
      1:       pd1 = d[23:0];
      default: pd2 = d;
    endcase
    pix_valid[i] = 1'b1;
    @(negedge clk);
    pix_valid[i] = 1'b0;
    check("ready_low_after_accept", 64'(pix_ready[i]), 64'd0);
  endtask

  task automatic wait_frame_end(input int i);
    int t = 0;
    while (bsy[i] && t < 20000) begin @(negedge clk); t++; end
    check("frame_end_bsy_low", 64'(bsy[i]), 64'd0);
    #1;
  endtask

  // ---- vector table: inputs plus expected done/underrun; frame length and pixels come from the model
  typedef struct {
    int              dut;
    int              npix;
    logic [2:0][31:0] pix;
    int              gap;
    int              exp_done;
    int              exp_urun;
  } vec_t;

  function automatic vec_t mkvec(input int dut, input int n, input logic [31:0] p0,
                                 input logic [31:0] p1, input logic [31:0] p2, input int gap);
    vec_t v;
    v.dut = dut; v.npix = n; v.gap = gap;
    v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2;
    v.exp_done = (n == nleds_of(dut)) ? 1 : 0;
    v.exp_urun = (n < nleds_of(dut)) ? 1 : 0;
    return v;
  endfunction

  function automatic int model_len(input vec_t v);
    int len = NRES;
    for (int k = 0; k < v.npix; k++)
      for (int b = bits_of(v.dut) - 1; b >= 0; b--)
        len += v.pix[k][b] ? (N1H + N1L) : (N0H + N0L);
    return len;
  endfunction

  task automatic run_frame(input vec_t v);
    int i  = v.dut;
    int d0 = done_cnt[i];
    int u0 = urun_cnt[i];
    rxq.delete();
    for (int k = 0; k < v.npix; k++) begin
      if (k > 0) repeat (v.gap) @(negedge clk);
      push(i, v.pix[k]);
      if (k == 0) begin
        @(negedge clk);
        check("start_dout", 64'(dout[i]), 64'd1);
        check("start_bsy", 64'(bsy[i]), 64'd1);
        check("start_ready", 64'(pix_ready[i]), 64'd1);
      end
    end
    wait_frame_end(i);
    check("done_count", 64'(done_cnt[i] - d0), 64'(v.exp_done));
    check("underrun_count", 64'(urun_cnt[i] - u0), 64'(v.exp_urun));
    check("rx_count", 64'(rxq.size()), 64'(v.npix));
    for (int k = 0; k < v.npix && k < rxq.size(); k++)
      check("rx_pixel", {32'd0, rxq[k].pix}, {32'd0, mask(v.pix[k], i)});
    check("frame_len", 64'(last_len[i]), 64'(model_len(v)));
  endtask

  vec_t vt[7];

  initial begin
    #(98000 * 10);
    $display("FAIL watchdog: cycle budget exceeded, %0d compared so far", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, lo, d0;
    rst = 1'b0; pix_valid = '0; pd0 = '0; pd1 = '0; pd2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      check("rst_dout", 64'(dout[i]), 64'd0);
      check("rst_bsy", 64'(bsy[i]), 64'd0);
      check("rst_ready", 64'(pix_ready[i]), 64'd1);
      check("rst_done", 64'(frame_done[i]), 64'd0);
      check("rst_underrun", 64'(underrun[i]), 64'd0);
    end

    vt[0] = mkvec(0, 1, 32'h00A5_0000, 32'h0, 32'h0, 0);
    vt[1] = mkvec(2, 1, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
    vt[2] = mkvec(1, 3, 32'h0012_3456, 32'h00FF_00AA, 32'h0081_7E01, 0);
    vt[3] = mkvec(1, 2, 32'h00C3_3C5A, 32'h0000_00FF, 32'h0, 5);
    for (int k = 4; k < 7; k++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 3;
      vt[k] = mkvec(1, n, $urandom & 32'hFF_FFFF, $urandom & 32'hFF_FFFF,
                    $urandom & 32'hFF_FFFF, int'($urandom_range(0, 100)));
    end
    for (int k = 0; k < 7; k++) run_frame(vt[k]);

    // pixel offered during LATCH is held and starts right after frame_done
    rxq.delete();
    d0 = done_cnt[0];
    push(0, 32'h0000_FF81);
    lo = 0; t = 0;
    while (lo < 200 && t < 20000) begin @(negedge clk); lo = dout[0] ? 0 : lo + 1; t++; end
    check("reached_latch", 64'(lo >= 200), 64'd1);
    push(0, 32'h003C_0000);
    t = 0;
    while (!frame_done[0] && t < 5000) begin @(negedge clk); t++; end
    check("latch_done_seen", 64'(frame_done[0]), 64'd1);
    check("held_at_done", 64'(pix_ready[0]), 64'd0);
    check("dout_low_at_done", 64'(dout[0]), 64'd0);
    @(negedge clk);
    check("tx_after_done", 64'(dout[0]), 64'd1);
    check("ready_after_load", 64'(pix_ready[0]), 64'd1);
    wait_frame_end(0);
    check("latch_rx_count", 64'(rxq.size()), 64'd2);
    if (rxq.size() == 2) begin
      check("latch_rx0", {32'd0, rxq[0].pix}, 64'h0000_FF81);
      check("latch_rx1", {32'd0, rxq[1].pix}, 64'h003C_0000);
    end
    check("latch_done_count", 64'(done_cnt[0] - d0), 64'd2);

    // asynchronous reset in the middle of a HIGH phase
    push(0, 32'h005A_5A5A);
    @(negedge clk);
    check("pre_rst_dout_high", 64'(dout[0]), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dout", 64'(dout[0]), 64'd0);
    check("async_rst_bsy", 64'(bsy[0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(pix_ready[0]), 64'd1);
    check("post_rst_bsy", 64'(bsy[0]), 64'd0);
    check("post_rst_dout", 64'(dout[0]), 64'd0);
    check("post_rst_done", 64'(frame_done[0]), 64'd0);
    run_frame(mkvec(0, 1, 32'h0012_3456, 32'h0, 32'h0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812_strip.md
# ws2812_strip

Parametrised WS2812/SK6812 strip driver and successor to the single-word transmitter. It accepts a stream of pixels over a valid/ready handshake and serialises a whole frame of `N_LEDS` pixels with no inter-pixel gap. Pixel width (24-bit RGB or 32-bit RGBW) and all bit timings are configurable. It appends the latch/reset low period automatically and reports frame completion and underruns. It sits between the pixel-generation logic and the LED data pin.

## Interface
- `F_CLK`, 48e6, clock frequency in Hz.
- `BITS`, 24, bits per pixel; only 24 or 32 are legal, anything else is an elaboration error.
- `N_LEDS`, 8, pixels per frame (≥1).
- `T0H_NS`, 350, high time of a 0 bit in ns.
- `T0L_NS`, 800, low time of a 0 bit in ns.
- `T1H_NS`, 700, high time of a 1 bit in ns.
- `T1L_NS`, 600, low time of a 1 bit in ns.
- `TRES_NS`, 80000, latch low time after a frame in ns.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `pix_data` in BITS: pixel, MSB transmitted first, already in LED byte order.
- `pix_valid` in 1: pixel offered.
- `pix_ready` out 1: holding register empty.
- `dout` out 1: LED data line, registered.
- `bsy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse at the end of the latch following a complete frame.
- `underrun` out 1: one-cycle pulse when a frame is truncated.

## Operation
- Cycle counts: N_x = ceil(T_x_NS·F_CLK/1e9), computed at elaboration.
  - Phase durations are exact: dout is high for exactly N_TxH cycles and low for exactly N_TxL cycles.
  - One shared down-counter is sized to clog2(max N + 1).
- Holding register: one entry.
  - A transfer occurs when `pix_valid && pix_ready`.
  - `pix_ready` = !full, derived from a register only and never from `pix_valid`.
  - Accepts in any state, including LATCH. Pixels accepted during LATCH belong to the next frame.
- Shift register (BITS wide) plus a bit index. The pixel counter is clog2(N_LEDS+1) wide.
- States:
  - IDLE: if the holding register is full, load the shift register, empty the holding register, set pixel count to 0, and go to HIGH. Otherwise stay.
  - HIGH: dout = 1 for N_T1H or N_T0H cycles, selected by the current MSB, then go to LOW.
  - LOW: dout = 0 for N_T1L or N_T0L cycles. Then:
    - More bits remain: shift, go to HIGH.
    - Last bit and pixel count = N_LEDS-1: go to LATCH.
    - Last bit, more pixels due, holding register full: load the next pixel and increment the count in the same cycle, go to HIGH. There is no gap between pixels.
    - Last bit, more pixels due, holding register empty: pulse `underrun`, go to LATCH. `frame_done` is not pulsed at the end of this latch.
  - LATCH: dout = 0 for N_RES cycles. Pulse `frame_done` on the exit cycle only if the frame was complete. Go to IDLE.
- A new frame never starts until LATCH has finished.
- Asynchronous reset, including mid-frame:
  - `dout` = 0, state = IDLE, holding register empty, counters = 0, pulses = 0.
  - `pix_ready` = 1 after reset is released.

## Timing
- Reset values:
  - `dout` 0
  - `bsy` 0
  - `pix_ready` 1
  - `frame_done` 0
  - `underrun` 0
- Latency:
  - Pixel accepted at edge k: holding register full after k.
  - IDLE→HIGH at edge k+1: `dout` rises after k+1, and `bsy` rises on the same edge.
- `pix_ready` falls the cycle after an accept. It rises the cycle after the holding register is transferred into the shift register.
- `frame_done`: high for the single cycle in which the state returns to IDLE. `bsy` falls on that same edge.
- `underrun`: high for the cycle in which LOW→LATCH occurs.
- If a pixel is accepted in the same cycle that LOW samples an empty holding register, it is too late for this frame: the underrun is taken, and the pixel is held for the next frame.

## Structure
- Package `ws2812_pkg`:
  - default timing constants in ns;
  - function `ns_to_cycles(ns, f_clk)` implementing ceil;
  - state encoding localparams: one-hot IDLE, HIGH, LOW, LATCH.
- Sub-module `ws2812_pix_buf`: one-entry valid/ready holding register with a load strobe. Everything else stays in `ws2812_strip`.

## Test plan
Cycle counts below are for F_CLK = 48e6, with all other parameters at their defaults unless a test overrides them.

- **Single pixel:** N_LEDS=1, pixel 0xA50000. Expect on `dout`: bit23 34H/29L; bit22 17H/39L; and so on for the remaining bits. Then 3840 cycles low. `frame_done` pulses once; `bsy` falls on that cycle.
- **Back-to-back frame:** N_LEDS=3, three pixels streamed. Expect 72 contiguous bits with no extra low cycles between pixels, `pix_ready` low while the holding register is full, and one `frame_done`.
- **Underrun:** N_LEDS=3, only 2 pixels supplied. Expect `underrun` pulsed after the last LOW phase of pixel 2, 3840 latch cycles, no `frame_done`, and `bsy` returning to 0.
- **RGBW:** BITS=32, pixel 0xFFFFFFFF. Expect 32 bits of 34H/29L, i.e. 2016 cycles, then latch.
- **Reset mid-bit:** assert `rst` low during HIGH. Expect `dout` = 0 immediately (asynchronous), `bsy` 0, `pix_ready` 1 after release. The next frame transmits correctly from bit 23.
- **Pixel during LATCH:** offer a pixel during LATCH. Expect it accepted and held, `dout` low for the full 3840 cycles, and the pixel transmitted starting the cycle after `frame_done`.
